// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake, operands (A, B) and results (quotient, remainder, div_by_zero) between a controller (master) and seq_divider (slave)
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  modport master (
    output start, A, B,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, A, B,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring unsigned divider, one quotient bit per clk, ports clk, reset, div (seq_divider_if.slave)
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic   clk,
  input logic   reset,
  seq_divider_if.slave div
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  logic [1:0]       state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;
  logic             ge;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;
  // The partial remainder is always below the divisor, so it fits in WIDTH bits;
  // only the shifted value needs the extra bit for an overflow-free compare.
  assign r_sh = {rem, q[WIDTH-1]};
  assign ge   = r_sh >= {1'b0, dsr};
  assign r_nx = ge ? WIDTH'(r_sh - {1'b0, dsr}) : r_sh[WIDTH-1:0];
  assign q_nx = {q[WIDTH-2:0], ge};
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      q         <= '0;
      dsr       <= '0;
      rem       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (div.start) begin
            q     <= div.A;
            dsr   <= div.B;
            rem   <= '0;
            cnt   <= '0;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          q   <= q_nx;
          rem <= r_nx;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            quotient  <= q_nx;
            remainder <= r_nx;
            dbz       <= dsr == '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign div.busy        = state == CALC;
  assign div.done        = state == DONE;
  assign div.quotient    = quotient;
  assign div.remainder   = remainder;
  assign div.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed self-checking bench for seq_divider against a cycle-count/arithmetic model
module tb_seq_divider;
  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  seq_divider_if #(.WIDTH(W)) dif ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .div(dif));
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int m_left = 0;
  bit m_done = 1'b0;
  bit m_z = 1'b0;
  int m_q = 0;
  int m_r = 0;
  bit p_z = 1'b0;
  int p_q = 0;
  int p_r = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: an accepted request finishes exactly W edges later with plain-arithmetic results.
  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_done = 1'b0;
      m_q = 0;
      m_r = 0;
      m_z = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_q = p_q;
          m_r = p_r;
          m_z = p_z;
        end
      end else if (dif.start) begin
        m_left = W;
        p_z = dif.B == 0;
        p_q = p_z ? MAXV : int'(dif.A) / int'(dif.B);
        p_r = p_z ? int'(dif.A) : int'(dif.A) % int'(dif.B);
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", dif.busy, m_left > 0);
      chk("done", dif.done, m_done);
      chk("quotient", dif.quotient, m_q);
      chk("remainder", dif.remainder, m_r);
      chk("div_by_zero", dif.div_by_zero, m_z);
    end
  end
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dif.done && n < 40);
    if (!dif.done) chk("done_timeout", dif.done, 1);
  endtask
  task automatic op(input int a, input int b, output int n);
    @(negedge clk);
    dif.start = 1'b1;
    dif.A = W'(a);
    dif.B = W'(b);
    @(negedge clk);
    dif.start = 1'b0;
    dif.A = W'($urandom);
    dif.B = W'($urandom);
    wait_done(n);
  endtask
  task automatic op_lit(input int a, input int b, input int eq, input int er, input int ez);
    int n;
    op(a, b, n);
    chk("latency", n, W);
    chk("lit_quotient", dif.quotient, eq);
    chk("lit_remainder", dif.remainder, er);
    chk("lit_div_by_zero", dif.div_by_zero, ez);
  endtask
  initial begin
    int n;
    int a;
    int b;
    bit seen;
    dif.start = 1'b0;
    dif.A = '0;
    dif.B = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", dif.busy, 0);
    chk("rst_done", dif.done, 0);
    chk("rst_quotient", dif.quotient, 0);
    chk("rst_remainder", dif.remainder, 0);
    reset = 1'b0;
    op_lit(255, 255, 1, 0, 0);
    @(negedge clk);
    dif.start = 1'b1;
    dif.A = 8'd11;
    dif.B = 8'd5;
    @(negedge clk);
    dif.A = 8'd255;
    dif.B = 8'd1;
    wait_done(n);
    chk("b2b_latency", n, W);
    chk("b2b1_quotient", dif.quotient, 2);
    chk("b2b1_remainder", dif.remainder, 1);
    @(negedge clk);
    dif.A = 8'd1;
    dif.B = 8'd255;
    wait_done(n);
    chk("b2b_gap", n + 1, W + 1);
    chk("b2b2_quotient", dif.quotient, 255);
    chk("b2b2_remainder", dif.remainder, 0);
    @(negedge clk);
    dif.start = 1'b0;
    wait_done(n);
    chk("b2b_gap", n + 1, W + 1);
    chk("b2b3_quotient", dif.quotient, 0);
    chk("b2b3_remainder", dif.remainder, 1);
    op_lit(200, 0, 255, 200, 1);
    op_lit(12, 4, 3, 0, 0);
    @(negedge clk);
    dif.start = 1'b1;
    dif.A = 8'd100;
    dif.B = 8'd7;
    @(negedge clk);
    dif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dif.start = 1'b1;
    dif.A = 8'd9;
    dif.B = 8'd3;
    @(negedge clk);
    dif.start = 1'b0;
    wait_done(n);
    chk("ignore_quotient", dif.quotient, 14);
    chk("ignore_remainder", dif.remainder, 2);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= dif.done;
    end
    chk("ignore_no_extra_done", seen, 0);
    @(negedge clk);
    dif.start = 1'b1;
    dif.A = 8'd250;
    dif.B = 8'd3;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", dif.busy, 0);
    chk("midrst_done", dif.done, 0);
    chk("midrst_quotient", dif.quotient, 0);
    chk("midrst_remainder", dif.remainder, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= dif.done;
    end
    chk("midrst_no_done", seen, 0);
    op_lit(250, 3, 83, 1, 0);
    for (int x = 0; x <= MAXV; x++) begin
      for (int y = 1; y <= MAXV; y++) begin
        if (x * y <= MAXV) begin
          op(x * y, y, n);
          chk("loop_quotient", dif.quotient, x);
          chk("loop_remainder", dif.remainder, 0);
        end
      end
    end
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, MAXV));
      b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, MAXV));
      op(a, b, n);
      chk("rand_latency", n, W);
      if (b != 0) begin
        chk("rand_invariant", int'(dif.quotient) * b + int'(dif.remainder), a);
        chk("rand_rem_lt_b", int'(dif.remainder) < b, 1);
      end else begin
        chk("rand_dz_quotient", dif.quotient, MAXV);
        chk("rand_dz_remainder", dif.remainder, a);
      end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
